// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// FSM states and per-slice compare outcomes.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SL_EQ,
    SL_GT,
    SL_LT
  } slice_res_t;

endpackage

// File: rtl/seq_magnitude_comparator_slice.sv
// Combinational CHUNK-bit slice compare.
// Optional MSB flip turns a two's-complement top slice into offset binary.
module slice_compare
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_sl,
  input  logic [CHUNK-1:0] b_sl,
  input  logic             flip_msb,
  output slice_res_t       res
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    flip = '0;
    flip[CHUNK-1] = flip_msb;
    a_x = a_sl ^ flip;
    b_x = b_sl ^ flip;
    res = SL_EQ;
    if (a_x > b_x) begin
      res = SL_GT;
    end else if (a_x < b_x) begin
      res = SL_LT;
    end
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: one CHUNK slice per cycle, MSB first,
// stops at the first unequal slice.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic signed_mode,
  output logic out_valid,
  input  logic out_ready,
  output logic A_gt_B,
  output logic A_eq_B,
  output logic A_lt_B,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0] slices_used
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int UW = $clog2(NSLICE + 1);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IDXW-1:0]  idx_q;
  logic [UW-1:0]    used_q;
  slice_res_t       res_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic             flip_msb;
  slice_res_t       sl_res;

  assign a_sl = a_q[idx_q*CHUNK +: CHUNK];
  assign b_sl = b_q[idx_q*CHUNK +: CHUNK];
  assign flip_msb = sm_q && (idx_q == TOP_IDX);

  slice_compare #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a_sl    (a_sl),
    .b_sl    (b_sl),
    .flip_msb(flip_msb),
    .res     (sl_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = COMPARE;
      end
      COMPARE: begin
        if (sl_res != SL_EQ || idx_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands and slice index carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q   <= A;
      b_q   <= B;
      sm_q  <= signed_mode;
      idx_q <= TOP_IDX;
    end else if (state_q == COMPARE) begin
      idx_q <= idx_q - IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      used_q <= '0;
      res_q  <= SL_EQ;
    end else if (state_q == IDLE && in_valid) begin
      used_q <= '0;
      res_q  <= SL_EQ;
    end else if (state_q == COMPARE) begin
      used_q <= used_q + UW'(1);
      res_q  <= sl_res;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign A_gt_B      = out_valid && (res_q == SL_GT);
  assign A_lt_B      = out_valid && (res_q == SL_LT);
  assign A_eq_B      = out_valid && (res_q == SL_EQ);
  assign slices_used = used_q;

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: slice width compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, NSLICE = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports A_gt_B, A_eq_B, A_lt_B  output  1 each  result flags.
REQ-013 SHALL have port slices_used  output  $clog2(NSLICE+1)  slices examined for current result (1..NSLICE).

Function
REQ-014 SHALL implement FSM states IDLE, COMPARE, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid && in_ready on a clock edge.
REQ-016 On transfer, SHALL register A, B, signed_mode, set slice index to NSLICE-1 (MSB slice), zero slices_used, go to COMPARE.
REQ-017 In COMPARE, SHALL compare exactly one CHUNK-bit slice per cycle, MSB slice first, and increment slices_used.
REQ-018 In signed mode, SHALL invert the MSB of both operands in the top slice only (offset-binary trick); lower slices are always unsigned.
REQ-019 On the first unequal slice, SHALL set exactly one of A_gt_B/A_lt_B and go to DONE (early termination).
REQ-020 If slice 0 is equal and all higher slices were equal, SHALL set A_eq_B and go to DONE.
REQ-021 Latency from accepting edge to out_valid=1 SHALL be exactly slices_used cycles (min 1, max NSLICE).
REQ-022 In DONE, SHALL hold out_valid=1 with flags and slices_used stable until out_ready=1; on that edge go to IDLE.
REQ-023 Flags SHALL be one-hot while out_valid=1 and all 0 while out_valid=0.
REQ-024 SHALL ignore in_valid and changes on A/B/signed_mode outside IDLE; no overlapping operations.
REQ-025 out_ready asserted before out_valid SHALL have no effect.
REQ-026 NSLICE=1 (CHUNK=WIDTH) SHALL be legal and give fixed latency 1.

Reset
REQ-027 When rst_n=0 at a clock edge, SHALL enter IDLE, with out_valid=0, all flags=0, slices_used=0, in_ready=1 from the next cycle.
REQ-028 Reset asserted mid-COMPARE or in DONE SHALL discard the operation; no result presented after release.
REQ-029 Operand registers need no reset; no output may depend on them while out_valid=0.

Structure
REQ-030 Package cmp_pkg SHALL hold the state enum type (IDLE/COMPARE/DONE) and the slice-result enum (SL_EQ/SL_GT/SL_LT).
REQ-031 SHALL instantiate one combinational sub-module slice_compare (params CHUNK; inputs a_sl, b_sl, flip_msb; output slice result) for the per-cycle compare.
REQ-032 NSLICE and index width SHALL be localparams derived from WIDTH/CHUNK; an elaboration check SHALL reject WIDTH % CHUNK != 0.

Verification
REQ-033 Unsigned, WIDTH=16, CHUNK=4: A=16'h1234, B=16'h1234 -> A_eq_B=1, slices_used=4, out_valid 4 cycles after accept.
REQ-034 Unsigned: A=16'h8000, B=16'h7FFF -> A_gt_B=1, slices_used=1; signed_mode=1, same operands -> A_lt_B=1, slices_used=1.
REQ-035 Unsigned: A=16'h12F0, B=16'h1300 -> A_lt_B=1, slices_used=2; out_ready held 0 for 5 cycles -> flags and out_valid stable, in_ready=0 throughout.
REQ-036 Signed: A=16'hFFFF (-1), B=16'h0000 -> A_lt_B=1; A=16'h0001, B=16'hFFFE -> A_gt_B=1.
REQ-037 Reset: accept A=B=16'hAAAA, drive rst_n=0 on 2nd COMPARE cycle for one cycle -> out_valid stays 0, in_ready=1 next cycle, following operation correct.
REQ-038 Exhaustive: WIDTH=4, CHUNK=2, all 256 pairs x both modes, random out_ready backpressure -> flags match reference model, one-hot, latency equals slices_used.
